// File: rtl/ahb_decoder_mux.sv
// rtl/ahb_decoder_mux.sv - AHB-lite address decoder with data-phase response multiplexer
//
// Purpose: decodes the master address phase into a one-hot slave select, registers
// the data-phase owner, and multiplexes the owning slave's HREADYOUT/HRESP/HRDATA
// back to the master. Unmapped NONSEQ/SEQ transfers get a two-cycle ERROR response
// from an internal default slave.
//
// Optional feature macro: AHB_DECODER_TIMEOUT_EN
//   When defined, a stalled slave is abandoned after TIMEOUT_CYCLES wait states
//   and the master receives a two-cycle ERROR response instead.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   m_addr   in   address-phase address from the master
//   m_trans  in   HTRANS (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
//   m_ready  out  HREADY to the master, also fanned out to every slave
//   m_rdata  out  muxed read data
//   m_resp   out  muxed response (0 OKAY, 1 ERROR)
//   s_sel    out  per-slave select, combinational from m_addr
//   s_rdata  in   per-slave read data
//   s_ready  in   per-slave HREADYOUT
//   s_resp   in   per-slave response

module ahb_decoder_mux #(
  parameter int                DEVICE_COUNT   = 4,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE [DEVICE_COUNT] = '{32'd0, 32'd2048, 32'd4096, 32'd8192},
  parameter logic [ADDR_W-1:0] SIZE [DEVICE_COUNT] = '{32'd2048, 32'd2048, 32'd4096, 32'd4096},
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [ADDR_W-1:0]                  m_addr,
  input  logic [1:0]                         m_trans,
  output logic                               m_ready,
  output logic [DATA_W-1:0]                  m_rdata,
  output logic                               m_resp,
  output logic [DEVICE_COUNT-1:0]            s_sel,
  input  logic [DEVICE_COUNT-1:0][DATA_W-1:0] s_rdata,
  input  logic [DEVICE_COUNT-1:0]            s_ready,
  input  logic [DEVICE_COUNT-1:0]            s_resp
);

  localparam int IDX_W = (DEVICE_COUNT > 1) ? $clog2(DEVICE_COUNT) : 1;

  if (DEVICE_COUNT < 1 || DEVICE_COUNT > 16) begin : g_bad_device_count
    $error("ahb_decoder_mux: DEVICE_COUNT must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ahb_decoder_mux: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {DSEL_NONE, DSEL_SLAVE, DSEL_DEFAULT} dsel_e;
  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} err_state_e;

  dsel_e            dsel_q, dsel_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  err_state_e       state_q, state_d;

  logic [DEVICE_COUNT-1:0] region_hit;
  logic                    addr_hit;
  logic [IDX_W-1:0]        hit_idx;
  logic                    xfer_active;
  logic                    load_default;
  logic                    timeout_fire;

  // Address decode. The offset test (m_addr - BASE) < SIZE cannot overflow once
  // m_addr >= BASE, so regions ending exactly at the top of the map still work.
  always_comb begin
    region_hit = '0;
    for (int i = 0; i < DEVICE_COUNT; i++) begin
      region_hit[i] = (m_addr >= BASE[i]) && ((m_addr - BASE[i]) < SIZE[i]);
    end
    addr_hit = |region_hit;
    // Walk downwards so the lowest matching index is the one left standing.
    hit_idx = '0;
    for (int i = DEVICE_COUNT - 1; i >= 0; i--) begin
      if (region_hit[i]) hit_idx = IDX_W'(i);
    end
    s_sel = '0;
    if (addr_hit) s_sel[hit_idx] = 1'b1;
  end

  assign xfer_active  = m_trans[1];
  assign load_default = m_ready && xfer_active && !addr_hit;

`ifdef AHB_DECODER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        slave_stall;

  assign slave_stall = (state_q == ST_OK) && (dsel_q == DSEL_SLAVE) && !s_ready[idx_q];
  // Fires on the edge that would take the count to TIMEOUT_CYCLES, so ERR1 is
  // presented right after the TIMEOUT_CYCLES-th wait state.
  assign timeout_fire = slave_stall && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = '0;
    if (slave_stall && !timeout_fire) tmo_cnt_d = tmo_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // Data-phase owner. Only an accepting edge (m_ready=1) moves it, except that a
  // timeout abandons the stalled slave regardless.
  always_comb begin
    dsel_d = dsel_q;
    idx_d  = idx_q;
    if (timeout_fire) begin
      dsel_d = DSEL_NONE;
    end else if (m_ready) begin
      if (!xfer_active) begin
        dsel_d = DSEL_NONE;
      end else if (addr_hit) begin
        dsel_d = DSEL_SLAVE;
        idx_d  = hit_idx;
      end else begin
        dsel_d = DSEL_DEFAULT;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dsel_q <= DSEL_NONE;
      idx_q  <= '0;
    end else begin
      dsel_q <= dsel_d;
      idx_q  <= idx_d;
    end
  end

  // Error FSM: state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_OK;
    else       state_q <= state_d;
  end

  // Error FSM: next state. ERR2 drives m_ready=1, so load_default there means a
  // back-to-back unmapped transfer and goes straight back to ERR1.
  always_comb begin
    state_d = ST_OK;
    case (state_q)
      ST_OK:   state_d = (load_default || timeout_fire) ? ST_ERR1 : ST_OK;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = load_default ? ST_ERR1 : ST_OK;
      default: state_d = ST_OK;
    endcase
  end

  // Error FSM: outputs, with the slave mux when no error is in progress.
  always_comb begin
    m_ready = 1'b1;
    m_resp  = 1'b0;
    m_rdata = '0;
    case (state_q)
      ST_ERR1: begin
        m_ready = 1'b0;
        m_resp  = 1'b1;
      end
      ST_ERR2: begin
        m_ready = 1'b1;
        m_resp  = 1'b1;
      end
      default: begin
        if (dsel_q == DSEL_SLAVE) begin
          m_ready = s_ready[idx_q];
          m_resp  = s_resp[idx_q];
          m_rdata = s_rdata[idx_q];
        end
      end
    endcase
  end

endmodule

// File: doc/ahb_decoder_mux.md
AHB_DECODER_MUX -- requirements
Module: ahb_decoder_mux

Interface
REQ-001 The block SHALL take one clock and an asynchronous, active-high reset, named `clock` and `reset`.
REQ-002 Parameter DEVICE_COUNT, 4, number of slave ports (1..16).
REQ-003 Parameter ADDR_W, 32, address width.
REQ-004 Parameter DATA_W, 32, data width.
REQ-005 Parameter BASE[DEVICE_COUNT], {0,2048,4096,8192}, region start address per slave.
REQ-006 Parameter SIZE[DEVICE_COUNT], {2048,2048,4096,4096}, region byte length per slave; 0 disables the region.
REQ-007 Parameter TIMEOUT_CYCLES, 255, stall limit; used only with the timeout feature (1..65535).
REQ-008 Port `clock`, in, 1: clock, rising edge.
REQ-009 Port `reset`, in, 1: asynchronous, active-high reset.
REQ-010 Port `m_addr`, in, ADDR_W: address-phase address from the master.
REQ-011 Port `m_trans`, in, 2: transfer kind (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
REQ-012 Port `m_ready`, out, 1: HREADY to the master; the same signal is fanned out to all slaves as HREADY in.
REQ-013 Port `m_rdata`, out, DATA_W: muxed read data.
REQ-014 Port `m_resp`, out, 1: muxed response (0 OKAY, 1 ERROR).
REQ-015 Port `s_sel`, out, DEVICE_COUNT: per-slave select.
REQ-016 Port `s_rdata`, in, DEVICE_COUNT x DATA_W: per-slave read data.
REQ-017 Port `s_ready`, in, DEVICE_COUNT: per-slave HREADYOUT.
REQ-018 Port `s_resp`, in, DEVICE_COUNT: per-slave response.

Function
REQ-019 Slave i SHALL match when BASE[i] <= m_addr < BASE[i]+SIZE[i]; on overlapping regions the lowest index wins.
REQ-020 s_sel SHALL be combinational from m_addr: one-hot for the winning match, all-zero when there is no match; it is independent of m_trans.
REQ-021 A registered data-phase select (DSEL: NONE, SLAVE[i], DEFAULT) SHALL load only on a rising edge where m_ready=1.
REQ-022 DSEL load value: SLAVE[i] for a matched NONSEQ/SEQ; DEFAULT for an unmatched NONSEQ/SEQ; NONE for IDLE/BUSY.
REQ-023 With DSEL=SLAVE[i], m_ready/m_resp/m_rdata SHALL equal s_ready[i]/s_resp[i]/s_rdata[i] combinationally (zero added latency).
REQ-024 With DSEL=NONE, the outputs SHALL be m_ready=1, m_resp=OKAY and m_rdata=0.
REQ-025 The error FSM SHALL have states OK, ERR1 and ERR2.
REQ-026 The error FSM SHALL move OK->ERR1 when DSEL loads DEFAULT.
REQ-027 In ERR1 the outputs SHALL be m_ready=0, m_resp=ERROR; the FSM SHALL then go to ERR2.
REQ-028 In ERR2 the outputs SHALL be m_ready=1, m_resp=ERROR; the FSM SHALL then go to OK.
REQ-029 The ERR2 cycle SHALL be an accept cycle: the address phase presented during ERR2 is decoded normally, and a back-to-back unmatched transfer re-enters ERR1.
REQ-030 m_rdata SHALL be 0 in ERR1 and ERR2.
REQ-031 A slave's own ERROR response SHALL pass through unchanged and SHALL NOT start the error FSM.

Reset
REQ-032 While reset is asserted: DSEL=NONE, FSM=OK, timeout counter=0, m_ready=1, m_resp=OKAY, m_rdata=0; s_sel still follows m_addr.
REQ-033 Reset asserted mid-transfer or mid-error SHALL abort immediately, asynchronously; the first post-reset edge with m_ready=1 accepts a fresh address phase.

Configuration
REQ-034 With macro AHB_DECODER_TIMEOUT_EN defined, a 16-bit counter SHALL increment each cycle where DSEL=SLAVE[i] and s_ready[i]=0, and clear whenever s_ready[i]=1.
REQ-035 With AHB_DECODER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the FSM SHALL enter ERR1, DSEL SHALL become NONE and the counter SHALL clear; the stalled slave's later outputs SHALL be ignored.
REQ-036 Without AHB_DECODER_TIMEOUT_EN, no counter SHALL exist and a stalled slave SHALL stall the master indefinitely.

Verification
REQ-037 Scenario: NONSEQ read at 0x0804, slave1 returns ready=1, rdata=0xDEADBEEF -> s_sel=0b0010, next cycle m_rdata=0xDEADBEEF, m_resp=OKAY, m_ready=1.
REQ-038 Scenario: NONSEQ at 0x4000 (unmapped) -> s_sel=0; next cycle m_ready=0/ERROR, then m_ready=1/ERROR, then OKAY.
REQ-039 Scenario: IDLE at 0x4000 -> m_ready=1, OKAY, zero wait states, no error.
REQ-040 Scenario: slave2 holds ready=0 for 3 cycles during a NONSEQ at 0x1000 -> m_ready=0 for exactly 3 cycles, the next transfer is accepted on the 4th cycle, and s_sel tracks the new address throughout.
REQ-041 Scenario: with AHB_DECODER_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave0 stalls forever -> ERR1 after 4 stall cycles, ERR2 next, then DSEL=NONE and m_ready=1.
REQ-042 Scenario: reset pulsed during ERR1 -> m_ready=1 and m_resp=OKAY within the same cycle, FSM=OK.
